// File: rtl/arith_pkg.sv
// ============================================================================
// Module   : arith_pkg
// Brief    : Shared widths, FSM state type and frame parity helper for the
//            arithmetic result serializer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package arith_pkg;

    localparam int FRAME_W = 8;
    localparam int RES_W   = 6;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    // Even parity bit over {mode, data}: makes the full frame carry an even count of ones.
    function automatic logic parity_of(input logic [RES_W:0] word);
        return ^word;
    endfunction

endpackage

`default_nettype wire

// File: rtl/result_fifo.sv
// ============================================================================
// Module   : result_fifo
// Brief    : Synchronous FIFO with occupancy count; head word is read
//            combinationally so a pop can consume it in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 7,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

`default_nettype wire

// File: rtl/arith_result_serializer.sv
// ============================================================================
// Module   : arith_result_serializer
// Brief    : Buffers mode-tagged adder/multiplier results and emits each as an
//            8-bit MSB-first even-parity serial frame with a frame strobe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arith_result_serializer
    import arith_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int BIT_DIV = 4,
    parameter int CNT_W   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             res_valid,
    input  logic             res_mode,
    input  logic [RES_W-1:0] res_data,
    output logic             res_ready,
    output logic             ser_data,
    output logic             ser_frame,
    output logic             busy,
    output logic [CNT_W-1:0] fifo_count,
    output logic             drop,
    input  logic             drop_clr
);

    localparam int                   DIV_W     = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam int                   BIT_CNT_W = $clog2(FRAME_W);
    localparam logic [DIV_W-1:0]     DIV_LAST  = DIV_W'(BIT_DIV - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST  = BIT_CNT_W'(FRAME_W - 1);

    state_e               state_q, state_d;
    logic [FRAME_W-1:0]   shreg_q, shreg_d;
    logic [BIT_CNT_W-1:0] bit_q, bit_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic                 drop_q, drop_d;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [RES_W:0]       fifo_rd_data;

    result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (RES_W + 1),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data ({res_mode, res_data}),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign res_ready = !fifo_full;
    assign fifo_push = res_valid && res_ready;
    assign drop      = drop_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            div_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            div_q   <= div_d;
            drop_q  <= drop_d;
        end
    end

    // A refused push outranks a simultaneous clear so no overflow goes unreported.
    always_comb begin
        drop_d   = (res_valid && !res_ready) ? 1'b1 : (drop_clr ? 1'b0 : drop_q);
        state_d  = state_q;
        shreg_d  = shreg_q;
        bit_d    = bit_q;
        div_d    = div_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = {fifo_rd_data, parity_of(fifo_rd_data)};
                    bit_d    = '0;
                    div_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
                    bit_d   = bit_q + BIT_CNT_W'(1);
                    if (bit_q == BIT_LAST) begin
                        state_d = IDLE;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ser_frame = (state_q == SHIFT);
        ser_data  = (state_q == SHIFT) ? shreg_q[FRAME_W-1] : 1'b0;
        busy      = (state_q == SHIFT) || !fifo_empty;
    end

endmodule

`default_nettype wire

// File: tb/tb_arith_result_serializer.sv
// ============================================================================
// Module   : tb_arith_result_serializer
// Brief    : Self-checking bench with a frame-position reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arith_result_serializer;

    localparam int DEPTH     = 4;
    localparam int BIT_DIV   = 4;
    localparam int CNT_W     = 3;
    localparam int FRAME_CYC = 8 * BIT_DIV;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       res_valid = 1'b0;
    logic       res_mode  = 1'b0;
    logic [5:0] res_data  = '0;
    logic       drop_clr  = 1'b0;
    logic       res_ready;
    logic       ser_data;
    logic       ser_frame;
    logic       busy;
    logic [CNT_W-1:0] fifo_count;
    logic       drop;

    always #5 clk = ~clk;

    arith_result_serializer #(
        .DEPTH   (DEPTH),
        .BIT_DIV (BIT_DIV),
        .CNT_W   (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .res_valid  (res_valid),
        .res_mode   (res_mode),
        .res_data   (res_data),
        .res_ready  (res_ready),
        .ser_data   (ser_data),
        .ser_frame  (ser_frame),
        .busy       (busy),
        .fifo_count (fifo_count),
        .drop       (drop),
        .drop_clr   (drop_clr)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit check_en = 1'b0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference model: a queue of pending words plus the position within the current frame.
    logic [6:0] m_q[$];
    bit         m_active = 1'b0;
    int         m_t      = 0;
    logic [7:0] m_frame  = '0;
    bit         m_drop   = 1'b0;

    initial forever begin
        bit ready;
        bit pop;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            m_q.delete();
            m_active = 1'b0;
            m_t      = 0;
            m_drop   = 1'b0;
        end else begin
            ready = (m_q.size() < DEPTH);
            pop   = !m_active && (m_q.size() != 0);
            if (pop) begin
                m_frame  = {m_q[0], ^m_q[0]};
                void'(m_q.pop_front());
                m_active = 1'b1;
                m_t      = 0;
            end else if (m_active && m_t == FRAME_CYC - 1) begin
                m_active = 1'b0;
            end else if (m_active) begin
                m_t++;
            end
            if (res_valid && ready) m_q.push_back({res_mode, res_data});
            if (res_valid && !ready) m_drop = 1'b1;
            else if (drop_clr)       m_drop = 1'b0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (check_en) begin
            check("ser_frame",  ser_frame,  m_active);
            check("ser_data",   ser_data,   m_active ? m_frame[7 - m_t / BIT_DIV] : 1'b0);
            check("fifo_count", fifo_count, m_q.size());
            check("res_ready",  res_ready,  m_q.size() < DEPTH);
            check("busy",       busy,       m_active || m_q.size() != 0);
            check("drop",       drop,       m_drop);
        end
    end

    // Frame capture from the pins: one sample per bit, recorded when the strobe falls.
    logic [7:0] cap_q[$];
    int         len_q[$];
    logic [7:0] cap        = '0;
    int         flen       = 0;
    int         rise_cyc   = 0;
    bit         prev_frame = 1'b0;

    initial forever begin
        @(negedge clk);
        if (ser_frame === 1'b1) begin
            if (!prev_frame) rise_cyc = cyc;
            if (flen % BIT_DIV == 0) cap = {cap[6:0], ser_data};
            flen++;
        end else if (prev_frame) begin
            cap_q.push_back(cap);
            len_q.push_back(flen);
            flen = 0;
        end
        prev_frame = (ser_frame === 1'b1);
    end

    int push_cyc = 0;

    task automatic push1(input logic mode, input logic [5:0] data);
        res_valid = 1'b1;
        res_mode  = mode;
        res_data  = data;
        @(posedge clk);
        #1;
        push_cyc  = cyc;
        res_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((m_active || m_q.size() != 0) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_timeout", n < 400, 1);
        @(negedge clk);
        #1;
    endtask

    initial begin
        int base;
        logic [6:0] w;
        logic [5:0] d;

        repeat (2) @(posedge clk);
        #1;
        check_en = 1'b1;
        check("rst_ser_frame", ser_frame, 0);
        check("rst_ser_data", ser_data, 0);
        check("rst_busy", busy, 0);
        check("rst_count", fifo_count, 0);
        check("rst_ready", res_ready, 1);
        check("rst_drop", drop, 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Single multiply result 42: frame 0101_0101
        push1(1'b0, 6'd42);
        wait_idle();
        check("mul42_bits", cap_q[$], 8'b0101_0101);
        check("mul42_len", len_q[$], 32);
        check("mul42_latency", rise_cyc - push_cyc, 1);

        // Single add result 13: frame 1001_1010
        push1(1'b1, 6'd13);
        wait_idle();
        check("add13_bits", cap_q[$], 8'b1001_1010);
        check("add13_latency", rise_cyc - push_cyc, 1);

        // Burst of six back-to-back pushes into DEPTH=4
        base = cap_q.size();
        for (int i = 1; i <= 6; i++) begin
            d         = 6'(i);
            res_valid = 1'b1;
            res_mode  = d[0];
            res_data  = d;
            if (i == 6) begin
                check("burst_ready6", res_ready, 0);
                check("burst_count6", fifo_count, 4);
            end
            @(posedge clk);
            #1;
        end
        res_valid = 1'b0;
        check("burst_drop_set", drop, 1);
        repeat (3) @(posedge clk);
        #1;
        check("burst_drop_sticky", drop, 1);
        drop_clr = 1'b1;
        @(posedge clk);
        #1;
        drop_clr = 1'b0;
        check("burst_drop_clr", drop, 0);
        wait_idle();
        check("burst_frames", cap_q.size() - base, 5);
        for (int i = 1; i <= 5; i++) begin
            d = 6'(i);
            w = {d[0], d};
            check("burst_order", cap_q[base + i - 1], {w, ^w});
        end

        // Continuous pushes while frames drain
        for (int k = 0; k < 400; k++) begin
            res_valid = ($urandom_range(0, 3) != 0);
            res_mode  = 1'($urandom_range(0, 1));
            res_data  = res_data + 6'd1;
            drop_clr  = ($urandom_range(0, 15) == 0);
            @(posedge clk);
            #1;
        end
        res_valid = 1'b0;
        drop_clr  = 1'b0;
        wait_idle();

        // Reset during bit 3 of a frame
        res_valid = 1'b1;
        res_mode  = 1'b1;
        res_data  = 6'h2d;
        @(posedge clk);
        #1;
        res_valid = 1'b0;
        @(posedge clk);
        #1;
        repeat (3 * BIT_DIV) @(posedge clk);
        #1;
        check("pre_rst_frame", ser_frame, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_frame", ser_frame, 0);
        check("midrst_count", fifo_count, 0);
        check("midrst_busy", busy, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push1(1'b0, 6'd35);
        wait_idle();
        check("post_rst_bits", cap_q[$], 8'b0100_0111);
        check("post_rst_len", len_q[$], FRAME_CYC);

        // Every {mode, data} combination
        for (int i = 0; i < 128; i++) begin
            w = 7'(i);
            push1(w[6], w[5:0]);
            wait_idle();
            check("sweep_word", cap_q[$], {w, ^w});
            check("sweep_even", $countones(cap_q[$]) % 2, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d of %0d passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule

`default_nettype wire
